// File: rtl/hazard_unit.sv
// Hazard unit for the 5-stage ARM-subset pipeline: operand forwarding, load-use stalls,
// branch/PC-write flushes, data-memory wait freezing and saturating hazard statistics.
module hazard_unit #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Match_1E_M,
    input  logic             Match_1E_W,
    input  logic             Match_2E_M,
    input  logic             Match_2E_W,
    input  logic             Match_12D_E,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             MemtoRegE,
    input  logic             BranchTakenE,
    input  logic             PCWrPendingF,
    input  logic             PCSrcW,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] ldstall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        PCDRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_mem_timeout;
    logic [CNT_W-1:0]  r_ldstall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    logic w_ldstall;
    logic w_mem_miss;
    logic w_freeze;
    logic w_timeout_hit;
    logic w_ldstall_event;

    assign w_ldstall  = Match_12D_E & MemtoRegE;
    assign w_mem_miss = MemReqM & ~MemReadyM;

    // A fresh miss freezes the pipe in the same cycle, before the state register catches up.
    assign w_freeze = reset & (w_mem_miss | ((r_state == MEMWAIT) & ~MemReadyM));

    assign w_timeout_hit   = w_freeze & (r_wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1));
    assign w_ldstall_event = reset & ~w_freeze & w_ldstall;

    // NOTE: every always_comb assigns all of its outputs first so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        if (w_mem_miss) begin
            w_next_state = MEMWAIT;
        end else begin
            case (r_state)
                MEMWAIT: if (MemReadyM) w_next_state = PCWrPendingF ? PCDRAIN : RUN;
                RUN:     if (PCWrPendingF) w_next_state = PCDRAIN;
                PCDRAIN: if (PCSrcW & ~PCWrPendingF) w_next_state = RUN;
                default: w_next_state = RUN;
            endcase
        end
    end

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        if (!reset) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushW = 1'b1;
        end else begin
            if (Match_1E_M & RegWriteM)      ForwardAE = 2'b10;
            else if (Match_1E_W & RegWriteW) ForwardAE = 2'b01;
            if (Match_2E_M & RegWriteM)      ForwardBE = 2'b10;
            else if (Match_2E_W & RegWriteW) ForwardBE = 2'b01;

            if (w_freeze) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else begin
                StallF = w_ldstall | PCWrPendingF;
                StallD = w_ldstall;
                FlushD = PCWrPendingF | PCSrcW | BranchTakenE;
                FlushE = w_ldstall | BranchTakenE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= RUN;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
            r_ldstall_cnt <= '0;
            r_flush_cnt   <= '0;
        end else begin
            r_state <= w_next_state;

            if (w_freeze) begin
                if (r_wait_cnt != WAIT_W'(MEM_TIMEOUT)) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end
            if (w_timeout_hit) r_mem_timeout <= 1'b1;

            if (w_ldstall_event && (r_ldstall_cnt != '1)) r_ldstall_cnt <= r_ldstall_cnt + CNT_W'(1);
            if (FlushE && (r_flush_cnt != '1))            r_flush_cnt   <= r_flush_cnt + CNT_W'(1);
        end
    end

    // The timeout is visible during the very cycle the wait length reaches the limit.
    assign mem_timeout = r_mem_timeout | w_timeout_hit;
    assign ldstall_cnt = r_ldstall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized traffic
// compared against a rule-level reference model.
module tb_hazard_unit;

    localparam int CNT_W       = 4;
    localparam int MEM_TIMEOUT = 64;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic clk;
    logic reset;
    logic Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E;
    logic RegWriteM, RegWriteW, MemtoRegE, BranchTakenE;
    logic PCWrPendingF, PCSrcW, MemReqM, MemReadyM;

    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushW;
    logic             mem_timeout;
    logic [CNT_W-1:0] ldstall_cnt, flush_cnt;
    logic [6:0]       ctl;

    int total;
    int bad;

    hazard_unit #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .Match_1E_M(Match_1E_M), .Match_1E_W(Match_1E_W),
        .Match_2E_M(Match_2E_M), .Match_2E_W(Match_2E_W), .Match_12D_E(Match_12D_E),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
        .BranchTakenE(BranchTakenE), .PCWrPendingF(PCWrPendingF), .PCSrcW(PCSrcW),
        .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .mem_timeout(mem_timeout), .ldstall_cnt(ldstall_cnt), .flush_cnt(flush_cnt)
    );

    // ctl packs {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_idle();
        reset = 1'b1;
        {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E} = '0;
        {RegWriteM, RegWriteW, MemtoRegE, BranchTakenE} = '0;
        {PCWrPendingF, PCSrcW, MemReqM, MemReadyM} = '0;
    endtask

    task automatic set_random_inputs();
        {Match_1E_M, Match_1E_W, Match_2E_M, Match_2E_W, Match_12D_E} = 5'($urandom);
        {RegWriteM, RegWriteW, MemtoRegE, BranchTakenE} = 4'($urandom);
        {PCWrPendingF, PCSrcW, MemReqM, MemReadyM} = 4'($urandom);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            set_random_inputs();
            reset = 1'b0;
            sample();
            total++;
            if (ctl !== 7'b0000111) begin
                bad++;
                $display("FAIL reset_ctl[%0d]: got %b expected %b", i, ctl, 7'b0000111);
            end
            total++;
            if ({ForwardAE, ForwardBE} !== 4'b0000) begin
                bad++;
                $display("FAIL reset_fwd[%0d]: got %b expected 0000", i, {ForwardAE, ForwardBE});
            end
            if (i == 1) begin
                total++;
                if ({ldstall_cnt, flush_cnt, mem_timeout} !== '0) begin
                    bad++;
                    $display("FAIL reset_counters: got ld=%0d fl=%0d to=%b expected 0 0 0",
                             ldstall_cnt, flush_cnt, mem_timeout);
                end
            end
            step();
        end
        set_idle();
        sample();
        total++;
        if (ctl !== 7'b0000000 || mem_timeout !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got ctl=%b to=%b expected 0000000 0", ctl, mem_timeout);
        end
        step();
    endtask

    task automatic test_forwarding();
        set_idle();
        sample();
        {Match_1E_M, Match_1E_W, RegWriteM, RegWriteW} = 4'b1111;
        #1;
        total++;
        if (ForwardAE !== 2'b10) begin
            bad++;
            $display("FAIL fwd_a_mem: got %b expected 10", ForwardAE);
        end
        RegWriteM = 1'b0;
        #1;
        total++;
        if (ForwardAE !== 2'b01) begin
            bad++;
            $display("FAIL fwd_a_wb: got %b expected 01", ForwardAE);
        end
        {Match_1E_M, Match_1E_W, Match_2E_W, RegWriteW} = 4'b0010;
        #1;
        total++;
        if (ForwardBE !== 2'b00 || ForwardAE !== 2'b00) begin
            bad++;
            $display("FAIL fwd_b_nowrite: got A=%b B=%b expected 00 00", ForwardAE, ForwardBE);
        end
        {Match_2E_M, RegWriteM, RegWriteW} = 3'b111;
        #1;
        total++;
        if (ForwardBE !== 2'b10) begin
            bad++;
            $display("FAIL fwd_b_mem: got %b expected 10", ForwardBE);
        end
        step();
        set_idle();
    endtask

    task automatic test_load_use();
        do_reset();
        {Match_12D_E, MemtoRegE} = 2'b11;
        sample();
        total++;
        if (ctl !== 7'b1100010) begin
            bad++;
            $display("FAIL load_use_ctl: got %b expected %b", ctl, 7'b1100010);
        end
        step();
        set_idle();
        sample();
        total++;
        if (ldstall_cnt !== CNT_W'(1) || flush_cnt !== CNT_W'(1) || ctl !== 7'b0) begin
            bad++;
            $display("FAIL load_use_after: got ld=%0d fl=%0d ctl=%b expected 1 1 0000000",
                     ldstall_cnt, flush_cnt, ctl);
        end
        step();
    endtask

    task automatic test_pc_drain();
        do_reset();
        PCWrPendingF = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sample();
            total++;
            if (ctl !== 7'b1000100) begin
                bad++;
                $display("FAIL pc_drain_pending[%0d]: got %b expected %b", i, ctl, 7'b1000100);
            end
            step();
        end
        PCWrPendingF = 1'b0;
        PCSrcW = 1'b1;
        sample();
        total++;
        if (ctl !== 7'b0000100) begin
            bad++;
            $display("FAIL pc_drain_retire: got %b expected %b", ctl, 7'b0000100);
        end
        step();
        set_idle();
        sample();
        total++;
        if (ctl !== 7'b0 || flush_cnt !== '0) begin
            bad++;
            $display("FAIL pc_drain_after: got ctl=%b fl=%0d expected 0000000 0", ctl, flush_cnt);
        end
        step();
    endtask

    task automatic test_mem_wait();
        do_reset();
        {MemReqM, MemReadyM} = 2'b10;
        for (int i = 0; i < 5; i++) begin
            sample();
            total++;
            if (ctl !== 7'b1111001 || mem_timeout !== 1'b0) begin
                bad++;
                $display("FAIL mem_wait[%0d]: got ctl=%b to=%b expected 1111001 0", i, ctl, mem_timeout);
            end
            step();
        end
        MemReadyM = 1'b1;
        sample();
        total++;
        if (ctl !== 7'b0) begin
            bad++;
            $display("FAIL mem_wait_release: got %b expected 0000000", ctl);
        end
        step();
        set_idle();
        sample();
        total++;
        if (ctl !== 7'b0 || mem_timeout !== 1'b0) begin
            bad++;
            $display("FAIL mem_wait_after: got ctl=%b to=%b expected 0000000 0", ctl, mem_timeout);
        end
        step();
    endtask

    task automatic test_timeout();
        do_reset();
        {MemReqM, MemReadyM, BranchTakenE} = 3'b101;
        for (int i = 1; i <= 70; i++) begin
            sample();
            total++;
            if (ctl !== 7'b1111001 || mem_timeout !== (i >= MEM_TIMEOUT)) begin
                bad++;
                $display("FAIL timeout_wait[%0d]: got ctl=%b to=%b expected 1111001 %b",
                         i, ctl, mem_timeout, (i >= MEM_TIMEOUT));
            end
            step();
        end
        MemReadyM = 1'b1;
        sample();
        total++;
        if (ctl !== 7'b0000110 || mem_timeout !== 1'b1) begin
            bad++;
            $display("FAIL timeout_release: got ctl=%b to=%b expected 0000110 1", ctl, mem_timeout);
        end
        step();
        set_idle();
        sample();
        total++;
        if (mem_timeout !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky: got %b expected 1", mem_timeout);
        end
        step();
        do_reset();
        sample();
        total++;
        if (mem_timeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_cleared: got %b expected 0", mem_timeout);
        end
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        {Match_12D_E, MemtoRegE, BranchTakenE} = 3'b111;
        for (int i = 0; i < 20; i++) begin
            sample();
            total++;
            if (ctl !== 7'b1100110) begin
                bad++;
                $display("FAIL ld_branch[%0d]: got %b expected %b", i, ctl, 7'b1100110);
            end
            step();
        end
        set_idle();
        sample();
        total++;
        if (ldstall_cnt !== CNT_W'(CNT_MAX) || flush_cnt !== CNT_W'(CNT_MAX)) begin
            bad++;
            $display("FAIL counter_saturate: got ld=%0d fl=%0d expected %0d %0d",
                     ldstall_cnt, flush_cnt, CNT_MAX, CNT_MAX);
        end
        step();
    endtask

    task automatic test_reset_midwait();
        do_reset();
        {MemReqM, MemReadyM} = 2'b10;
        for (int i = 0; i < 3; i++) step();
        reset = 1'b0;
        sample();
        total++;
        if (ctl !== 7'b0000111) begin
            bad++;
            $display("FAIL midwait_reset: got %b expected 0000111", ctl);
        end
        step();
        set_idle();
        sample();
        total++;
        if (ctl !== 7'b0) begin
            bad++;
            $display("FAIL midwait_release: got %b expected 0000000", ctl);
        end
        step();
    endtask

    // Reference model: only an outstanding memory wait is observable state; draining a
    // PC write uses the same output rules as normal running.
    task automatic test_random();
        bit  m_in_wait = 1'b0;
        bit  m_to = 1'b0;
        int  m_len = 0;
        int  m_ld = 0;
        int  m_fl = 0;
        bit  ld, freeze, exp_to;
        logic [1:0] exp_a, exp_b;
        logic [6:0] exp_ctl;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            set_random_inputs();
            MemReqM   = ($urandom_range(0, 2) == 0);
            MemReadyM = ((cyc % 600) < 90) ? 1'b0 : ($urandom_range(0, 3) != 0);
            reset     = (cyc == 0) ? 1'b0 : ($urandom_range(0, 59) != 0);

            ld     = Match_12D_E && MemtoRegE;
            freeze = reset && !MemReadyM && (MemReqM || m_in_wait);
            if (!reset) begin
                exp_a = 2'b00;
                exp_b = 2'b00;
                exp_ctl = 7'b0000111;
            end else begin
                exp_a = (Match_1E_M && RegWriteM) ? 2'd2 : (Match_1E_W && RegWriteW) ? 2'd1 : 2'd0;
                exp_b = (Match_2E_M && RegWriteM) ? 2'd2 : (Match_2E_W && RegWriteW) ? 2'd1 : 2'd0;
                if (freeze) exp_ctl = 7'b1111001;
                else exp_ctl = {ld | PCWrPendingF, ld, 2'b00,
                                PCWrPendingF | PCSrcW | BranchTakenE, ld | BranchTakenE, 1'b0};
            end
            exp_to = m_to || (freeze && (m_len + 1 >= MEM_TIMEOUT));

            sample();
            total++;
            if ({ForwardAE, ForwardBE} !== {exp_a, exp_b}) begin
                bad++;
                $display("FAIL rand_fwd[%0d]: got %b expected %b", cyc, {ForwardAE, ForwardBE}, {exp_a, exp_b});
            end
            total++;
            if (ctl !== exp_ctl) begin
                bad++;
                $display("FAIL rand_ctl[%0d]: got %b expected %b", cyc, ctl, exp_ctl);
            end
            total++;
            if (mem_timeout !== exp_to) begin
                bad++;
                $display("FAIL rand_timeout[%0d]: got %b expected %b", cyc, mem_timeout, exp_to);
            end
            total++;
            if (ldstall_cnt !== CNT_W'(m_ld) || flush_cnt !== CNT_W'(m_fl)) begin
                bad++;
                $display("FAIL rand_counters[%0d]: got ld=%0d fl=%0d expected %0d %0d",
                         cyc, ldstall_cnt, flush_cnt, m_ld, m_fl);
            end
            step();

            if (!reset) begin
                m_in_wait = 1'b0;
                m_to = 1'b0;
                m_len = 0;
                m_ld = 0;
                m_fl = 0;
            end else begin
                m_in_wait = freeze;
                if (freeze && (m_len + 1 >= MEM_TIMEOUT)) m_to = 1'b1;
                m_len = freeze ? m_len + 1 : 0;
                if (!freeze && ld && m_ld < CNT_MAX) m_ld++;
                if (!freeze && (ld || BranchTakenE) && m_fl < CNT_MAX) m_fl++;
            end
        end
        set_idle();
    endtask

    initial begin
        total = 0;
        bad = 0;
        set_idle();
        step();
        test_reset();
        test_forwarding();
        test_load_use();
        test_pc_drain();
        test_mem_wait();
        test_timeout();
        test_back_to_back();
        test_reset_midwait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
